sram_test_sequencer: RTL and testbench

- Traffic generator and checker that sits directly upstream of the SRAM basic controller and drives its rw/addr/data_f2s inputs.
- Consumes the controller's registered read data, data_s2f_r.
- On start, writes a seeded pattern to addresses 0..ADDR_LAST, reads every location back, and compares each read against the expected value.
- Reports busy/done/pass, a saturating error count, and the address of the first mismatch, for the board-level tester.

---
 rtl/sram_test_sequencer_if.sv | 14 +
 rtl/sram_test_sequencer.sv | 170 +++++++++++++++++
 tb/tb_sram_test_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_test_sequencer_if.sv
// Bus between the SRAM test sequencer and the SRAM basic controller.
// The sequencer is the master: it drives rw/addr/write data and reads back the registered data.
interface sram_test_sequencer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_f2s;
  logic [DATA_W-1:0] data_s2f_r;

  modport master (output rw, output addr, output data_f2s, input data_s2f_r);
  modport slave  (input rw, input addr, input data_f2s, output data_s2f_r);
endinterface

// File: rtl/sram_test_sequencer.sv
// SRAM write/read-back tester: writes a seeded pattern to 0..ADDR_LAST, reads every
// location back, and reports pass/fail, a saturating error count and the first failing address.
module sram_test_sequencer #(
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(19'h7FFFF),
  parameter int                WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  sram_test_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_W_SETUP = 3'd1;
  localparam logic [2:0] S_W_PULSE = 3'd2;
  localparam logic [2:0] S_W_HOLD  = 3'd3;
  localparam logic [2:0] S_R_WAIT  = 3'd4;
  localparam logic [2:0] S_R_CMP   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  logic [2:0]        state_q, state_d;
  logic [3:0]        phase_q, phase_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;

  function automatic logic [DATA_W-1:0] exp_f(input logic [ADDR_W-1:0] a,
                                               input logic [DATA_W-1:0] s);
    return a[DATA_W-1:0] ^ s;
  endfunction

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    seed_d  = seed_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        rw_d   = 1'b1;
        addr_d = '0;
        if (state_q == S_IDLE) data_d = '0;
        if (start) begin
          seed_d  = seed;
          err_d   = '0;
          ferr_d  = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          data_d  = exp_f('0, seed);
          state_d = S_W_SETUP;
        end
      end
      S_W_SETUP: begin
        rw_d    = 1'b0;
        phase_d = 4'd1;
        state_d = S_W_PULSE;
      end
      S_W_PULSE: begin
        if (phase_q == WAIT_C) begin
          rw_d    = 1'b1;
          state_d = S_W_HOLD;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      S_W_HOLD: begin
        // Read-back starts at address 0 with write data parked at zero.
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          data_d  = '0;
          phase_d = 4'd1;
          state_d = S_R_WAIT;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          data_d  = exp_f(addr_q + ADDR_W'(1), seed_q);
          state_d = S_W_SETUP;
        end
      end
      S_R_WAIT: begin
        if (phase_q == WAIT_C) state_d = S_R_CMP;
        else                   phase_d = phase_q + 4'd1;
      end
      S_R_CMP: begin
        if (bus.data_s2f_r != exp_f(addr_q, seed_q)) begin
          if (err_q == 16'd0)     ferr_d = addr_q;
          if (err_q != 16'hFFFF)  err_d  = err_q + 16'd1;
        end
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 16'd0);
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          phase_d = 4'd1;
          state_d = S_R_WAIT;
        end
      end
      default: begin
        rw_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  // The seed is only meaningful once a run has been accepted, so it is not reset.
  always_ff @(posedge clk) begin
    seed_q <= seed_d;
  end

  assign bus.rw         = rw_q;
  assign bus.addr       = addr_q;
  assign bus.data_f2s   = data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_sram_test_sequencer.sv
// Bench for sram_test_sequencer: a 4-address instance and a single-address instance,
// each driving a small SRAM model, with write traffic checked against a scoreboard queue.
module tb_sram_test_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance 0: ADDR_LAST=3, WAIT_CYCLES=2
  logic        st0;
  logic [7:0]  seed0;
  logic        busy0, done0, pass0;
  logic [15:0] err0;
  logic [18:0] ferr0;
  sram_test_sequencer_if #(.ADDR_W(19), .DATA_W(8)) if0 ();
  sram_test_sequencer #(.ADDR_W(19), .DATA_W(8), .ADDR_LAST(19'd3), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .reset(reset), .start(st0), .seed(seed0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .first_err_addr(ferr0), .bus(if0));

  // Instance 1: ADDR_LAST=0, WAIT_CYCLES=1
  logic        st1;
  logic [7:0]  seed1;
  logic        busy1, done1, pass1;
  logic [15:0] err1;
  logic [18:0] ferr1;
  sram_test_sequencer_if #(.ADDR_W(19), .DATA_W(8)) if1 ();
  sram_test_sequencer #(.ADDR_W(19), .DATA_W(8), .ADDR_LAST(19'd0), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .start(st1), .seed(seed1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .first_err_addr(ferr1), .bus(if1));

  // SRAM models with registered read data; fault0: 0 ideal, 1 addr 2 reads 00, 2 bit0 stuck at 1
  logic [7:0] mem0 [0:3];
  logic [7:0] mem1;
  logic [7:0] rd0, rd1;
  int fault0 = 0;
  assign if0.data_s2f_r = rd0;
  assign if1.data_s2f_r = rd1;

  always @(posedge clk) begin
    if (if0.rw === 1'b0) mem0[if0.addr[1:0]] <= if0.data_f2s;
    case (fault0)
      1:       rd0 <= (if0.addr[1:0] == 2'd2) ? 8'h00 : mem0[if0.addr[1:0]];
      2:       rd0 <= mem0[if0.addr[1:0]] | 8'h01;
      default: rd0 <= mem0[if0.addr[1:0]];
    endcase
    if (if1.rw === 1'b0) mem1 <= if1.data_f2s;
    rd1 <= mem1;
  end

  // Write scoreboards: {addr, data} expected per write pulse, popped on each falling rw
  logic [26:0] wq0 [$];
  logic [26:0] wq1 [$];
  logic [26:0] ew0, ew1;
  int lowrun0 = 0, lowrun1 = 0;
  int wcnt0 = 0, wcnt1 = 0;

  always begin : mon0
    @(posedge clk); #1;
    if (reset) lowrun0 = 0;
    else if (if0.rw === 1'b0) begin
      if (lowrun0 == 0) begin
        wcnt0++;
        total++;
        if (wq0.size() == 0) begin
          bad++;
          $display("FAIL wr0_unexpected: got addr=%0h data=%0h want no write", if0.addr, if0.data_f2s);
        end else begin
          ew0 = wq0.pop_front();
          if ({if0.addr, if0.data_f2s} !== ew0) begin
            bad++;
            $display("FAIL wr0_data: got addr=%0h data=%0h want addr=%0h data=%0h",
                     if0.addr, if0.data_f2s, ew0[26:8], ew0[7:0]);
          end
        end
      end
      lowrun0++;
    end else begin
      if (lowrun0 != 0) begin
        total++;
        if (lowrun0 != 2) begin
          bad++;
          $display("FAIL wr0_pulse_len: got %0d want 2", lowrun0);
        end
      end
      lowrun0 = 0;
    end
  end

  always begin : mon1
    @(posedge clk); #1;
    if (reset) lowrun1 = 0;
    else if (if1.rw === 1'b0) begin
      if (lowrun1 == 0) begin
        wcnt1++;
        total++;
        if (wq1.size() == 0) begin
          bad++;
          $display("FAIL wr1_unexpected: got addr=%0h data=%0h want no write", if1.addr, if1.data_f2s);
        end else begin
          ew1 = wq1.pop_front();
          if ({if1.addr, if1.data_f2s} !== ew1) begin
            bad++;
            $display("FAIL wr1_data: got addr=%0h data=%0h want addr=%0h data=%0h",
                     if1.addr, if1.data_f2s, ew1[26:8], ew1[7:0]);
          end
        end
      end
      lowrun1++;
    end else begin
      if (lowrun1 != 0) begin
        total++;
        if (lowrun1 != 1) begin
          bad++;
          $display("FAIL wr1_pulse_len: got %0d want 1", lowrun1);
        end
      end
      lowrun1 = 0;
    end
  end

  // Stimulus utilities: queue the expected pattern, pulse start across one edge, wait for done
  task automatic kick0(input logic [7:0] s, input int fault);
    fault0 = fault;
    for (int a = 0; a < 4; a++) wq0.push_back({19'(a), 8'(a) ^ s});
    @(negedge clk);
    seed0 = s;
    st0   = 1'b1;
    @(posedge clk); #1;
    st0   = 1'b0;
  endtask

  task automatic wait_done0(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (done0 !== 1'b1 && cyc < 400);
    if (done0 !== 1'b1) begin
      total++; bad++;
      $display("FAIL done0_timeout: got done=%b after %0d cycles want 1", done0, cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; st0 = 1'b0; st1 = 1'b0; seed0 = '0; seed1 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (if0.rw !== 1'b1)    begin bad++; $display("FAIL rst_rw: got %b want 1", if0.rw); end
    total++; if (if0.addr !== 19'd0) begin bad++; $display("FAIL rst_addr: got %0h want 0", if0.addr); end
    total++; if (if0.data_f2s !== 8'd0) begin bad++; $display("FAIL rst_data: got %0h want 0", if0.data_f2s); end
    total++; if ({busy0, done0, pass0} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {busy0, done0, pass0}); end
    total++; if (err0 !== 16'd0 || ferr0 !== 19'd0) begin bad++; $display("FAIL rst_err: got %0h/%0h want 0/0", err0, ferr0); end
    total++; if (if1.rw !== 1'b1 || busy1 !== 1'b0) begin bad++; $display("FAIL rst_u1: got rw=%b busy=%b want 1/0", if1.rw, busy1); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    int w0;
    w0 = wcnt0;
    kick0(8'hA5, 0);
    total++; if (busy0 !== 1'b1 || if0.rw !== 1'b1) begin bad++; $display("FAIL basic_busy: got busy=%b rw=%b want 1/1", busy0, if0.rw); end
    wait_done0(cyc);
    total++; if (cyc != 28) begin bad++; $display("FAIL basic_latency: got %0d want 28", cyc); end
    total++; if (pass0 !== 1'b1 || err0 !== 16'd0) begin bad++; $display("FAIL basic_pass: got pass=%b err=%0d want 1/0", pass0, err0); end
    total++; if (busy0 !== 1'b0 || if0.rw !== 1'b1 || if0.addr !== 19'd0) begin bad++; $display("FAIL basic_done_bus: got busy=%b rw=%b addr=%0h want 0/1/0", busy0, if0.rw, if0.addr); end
    total++; if (wcnt0 - w0 != 4 || wq0.size() != 0) begin bad++; $display("FAIL basic_writes: got %0d left=%0d want 4/0", wcnt0 - w0, wq0.size()); end
  endtask

  task automatic test_addr2_fault();
    int cyc;
    kick0(8'hA5, 1);
    wait_done0(cyc);
    total++; if (err0 !== 16'd1)   begin bad++; $display("FAIL a2_err: got %0d want 1", err0); end
    total++; if (ferr0 !== 19'd2)  begin bad++; $display("FAIL a2_first: got %0h want 2", ferr0); end
    total++; if (pass0 !== 1'b0 || done0 !== 1'b1) begin bad++; $display("FAIL a2_pass: got pass=%b done=%b want 0/1", pass0, done0); end
  endtask

  task automatic test_stuck_bit();
    int cyc;
    kick0(8'h00, 2);
    wait_done0(cyc);
    total++; if (err0 !== 16'd2)  begin bad++; $display("FAIL stuck_err: got %0d want 2", err0); end
    total++; if (ferr0 !== 19'd0) begin bad++; $display("FAIL stuck_first: got %0h want 0", ferr0); end
    total++; if (pass0 !== 1'b0)  begin bad++; $display("FAIL stuck_pass: got %b want 0", pass0); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    kick0(8'hFF, 0);
    total++; if (err0 !== 16'd0 || ferr0 !== 19'd0) begin bad++; $display("FAIL b2b_clear: got err=%0d first=%0h want 0/0", err0, ferr0); end
    total++; if (done0 !== 1'b0 || pass0 !== 1'b0 || busy0 !== 1'b1) begin bad++; $display("FAIL b2b_flags: got done=%b pass=%b busy=%b want 0/0/1", done0, pass0, busy0); end
    wait_done0(cyc);
    total++; if (cyc != 28 || pass0 !== 1'b1) begin bad++; $display("FAIL b2b_run: got cyc=%0d pass=%b want 28/1", cyc, pass0); end
    total++; if (wq0.size() != 0) begin bad++; $display("FAIL b2b_writes: got %0d pending want 0", wq0.size()); end
  endtask

  task automatic test_start_ignored_reset();
    int n;
    kick0(8'hA5, 0);
    n = 0;
    while (!(if0.rw === 1'b0 && if0.addr === 19'd1) && n < 100) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    st0 = 1'b1; seed0 = 8'h11;
    @(negedge clk);
    st0 = 1'b0;
    n = 0;
    while (!(if0.rw === 1'b0 && if0.addr === 19'd3) && n < 100) begin @(posedge clk); #1; n++; end
    while (if0.rw !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    total++; if (busy0 !== 1'b1 || if0.rw !== 1'b1 || if0.addr !== 19'd0 || n >= 200) begin bad++; $display("FAIL ign_rwait: got busy=%b rw=%b addr=%0h want 1/1/0", busy0, if0.rw, if0.addr); end
    total++; if (wq0.size() != 0) begin bad++; $display("FAIL ign_writes: got %0d pending want 0", wq0.size()); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (if0.rw !== 1'b1 || if0.addr !== 19'd0 || if0.data_f2s !== 8'd0) begin bad++; $display("FAIL mid_rst_bus: got rw=%b addr=%0h data=%0h want 1/0/0", if0.rw, if0.addr, if0.data_f2s); end
    total++; if ({busy0, done0, pass0} !== 3'b000 || err0 !== 16'd0 || ferr0 !== 19'd0) begin bad++; $display("FAIL mid_rst_status: got %b err=%0d first=%0h want 000/0/0", {busy0, done0, pass0}, err0, ferr0); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy0 !== 1'b0 || if0.rw !== 1'b1 || done0 !== 1'b0) begin bad++; $display("FAIL mid_rst_idle: got busy=%b rw=%b done=%b want 0/1/0", busy0, if0.rw, done0); end
  endtask

  task automatic test_single();
    int cyc;
    wq1.push_back({19'd0, 8'h3C});
    @(negedge clk);
    seed1 = 8'h3C;
    st1   = 1'b1;
    @(posedge clk); #1;
    st1   = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (done1 !== 1'b1 && cyc < 100);
    total++; if (cyc != 5) begin bad++; $display("FAIL single_latency: got %0d want 5", cyc); end
    total++; if (pass1 !== 1'b1 || err1 !== 16'd0) begin bad++; $display("FAIL single_pass: got pass=%b err=%0d want 1/0", pass1, err1); end
    total++; if (wcnt1 != 1 || wq1.size() != 0) begin bad++; $display("FAIL single_writes: got %0d left=%0d want 1/0", wcnt1, wq1.size()); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem0[i] = 8'h00;
    mem1 = 8'h00;
    test_reset();
    test_basic();
    test_addr2_fault();
    test_stuck_bit();
    test_back_to_back();
    test_start_ignored_reset();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
